// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader_pkg
//  Description : Shared types and byte codes for the UART RAM loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_CNT_HI  = 3'd3,
        ST_CNT_LO  = 3'd4,
        ST_DATA    = 3'd5,
        ST_WRITE   = 3'd6,
        ST_RESP    = 3'd7
    } state_t;

    // Command and response byte codes.
    localparam logic [7:0] CMD_WRITE = 8'hA5;
    localparam logic [7:0] CMD_RUN   = 8'hFF;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

endpackage : uart_loader_pkg
`default_nettype wire

// File: rtl/uart_byte_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_fetch
//  Description : RX FIFO read handshake (one rdreq, capture next cycle) and
//                inter-byte idle timeout counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_fetch
    import uart_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       want,
    input  logic       tmo_en,
    input  logic       rx_empty,
    input  logic [7:0] rx_q,
    output logic       rx_rdreq,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic             r_cap;
    logic [CNT_W-1:0] r_idle;

    // Timeout fires on the TIMEOUT_CYC-th consecutive cycle without a byte.
    // The >= keeps it asserted if it first lands in a non-fetching cycle.
    assign timeout    = tmo_en && !r_cap && (r_idle >= CNT_W'(TIMEOUT_CYC - 1));

    // No request in the capture cycle, so at most one byte per two cycles.
    // A request is also withheld when the packet is being aborted.
    assign rx_rdreq   = !rst && want && !rx_empty && !r_cap && !timeout;
    assign byte_valid = r_cap;
    assign data_byte  = rx_q;

    // Capture flag: FIFO output is valid the cycle after the read request.
    always_ff @(posedge clk) begin
        if (rst) r_cap <= 1'b0;
        else     r_cap <= rx_rdreq;
    end

    // Idle counter, cleared on every captured byte and outside packets.
    always_ff @(posedge clk) begin
        if (rst || !tmo_en || r_cap) r_idle <= '0;
        else if (!timeout)           r_idle <= r_idle + CNT_W'(1);
    end

endmodule : uart_byte_fetch
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader
//  Description : Decodes WRITE/RUN commands from the RX FIFO, writes 32-bit
//                words into RAM, answers ACK/NAK via the TX FIFO and
//                releases the CORE with a sticky run flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_empty,
    input  logic [7:0]        rx_q,
    output logic              rx_rdreq,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              tx_wrreq,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_we,
    output logic              core_run,
    output logic              busy
);

    state_t              r_state;
    state_t              w_next;
    logic                w_want;
    logic                w_tmo_en;
    logic                w_set_resp;
    logic [7:0]          w_resp_val;
    logic                w_set_run;
    logic [7:0]          w_ok_resp;

    logic                w_byte_valid;
    logic [7:0]          w_byte;
    logic                w_timeout;
    logic [15:0]         w_half;

    logic [7:0]          r_hi;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [15:0]         r_cnt;
    logic [1:0]          r_bidx;
    logic [23:0]         r_word;
    logic [7:0]          r_resp;
    logic                r_run;

    uart_byte_fetch #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fetch (
        .clk        (clk),
        .rst        (rst),
        .want       (w_want),
        .tmo_en     (w_tmo_en),
        .rx_empty   (rx_empty),
        .rx_q       (rx_q),
        .rx_rdreq   (rx_rdreq),
        .byte_valid (w_byte_valid),
        .data_byte  (w_byte),
        .timeout    (w_timeout)
    );

    // Big-endian 16-bit field from the stored high byte and the current byte;
    // only the low ADDR_W bits of an address are kept.
    assign w_half    = {r_hi, w_byte};
    // While the CORE owns RAM a completed WRITE is refused.
    assign w_ok_resp = r_run ? RSP_NAK : RSP_ACK;

    assign ram_we   = (r_state == ST_WRITE) && !r_run;
    assign tx_wrreq = (r_state == ST_RESP) && !tx_full;
    assign tx_data  = r_resp;
    assign busy     = (r_state != ST_IDLE);
    assign core_run = r_run;
    assign w_tmo_en = (r_state != ST_IDLE) && (r_state != ST_RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode, byte demand and response selection.
    always_comb begin
        w_next     = r_state;
        w_want     = 1'b0;
        w_set_resp = 1'b0;
        w_resp_val = RSP_NAK;
        w_set_run  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_want = 1'b1;
                if (w_byte_valid) begin
                    if (w_byte == CMD_WRITE) begin
                        w_next = ST_ADDR_HI;
                    end else if (w_byte == CMD_RUN) begin
                        w_set_run  = 1'b1;
                        w_set_resp = 1'b1;
                        w_resp_val = RSP_ACK;
                        w_next     = ST_RESP;
                    end else begin
                        w_set_resp = 1'b1;
                        w_resp_val = RSP_NAK;
                        w_next     = ST_RESP;
                    end
                end
            end
            ST_ADDR_HI: begin
                w_want = 1'b1;
                if (w_byte_valid) w_next = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
                w_want = 1'b1;
                if (w_byte_valid) w_next = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                w_want = 1'b1;
                if (w_byte_valid) w_next = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                w_want = 1'b1;
                if (w_byte_valid) begin
                    if (w_half == 16'd0) begin
                        w_set_resp = 1'b1;
                        w_resp_val = w_ok_resp;
                        w_next     = ST_RESP;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                w_want = 1'b1;
                if (w_byte_valid && (r_bidx == 2'd3)) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (r_cnt == 16'd1) begin
                    w_set_resp = 1'b1;
                    w_resp_val = w_ok_resp;
                    w_next     = ST_RESP;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_RESP: begin
                if (!tx_full) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // A stalled packet is abandoned with a NAK; WRITE completes first.
        if (w_timeout && (r_state != ST_WRITE)) begin
            w_set_resp = 1'b1;
            w_resp_val = RSP_NAK;
            w_next     = ST_RESP;
        end
    end

    // Datapath: header fields, word assembly, RAM outputs, response, run flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= '0;
            r_wr_addr <= '0;
            r_cnt     <= '0;
            r_bidx    <= '0;
            r_word    <= '0;
            r_resp    <= '0;
            r_run     <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
        end else begin
            if (w_set_resp) r_resp <= w_resp_val;
            if (w_set_run)  r_run  <= 1'b1;
            if (w_byte_valid) begin
                case (r_state)
                    ST_ADDR_HI, ST_CNT_HI: r_hi <= w_byte;
                    ST_ADDR_LO:            r_wr_addr <= w_half[ADDR_W-1:0];
                    ST_CNT_LO: begin
                        r_cnt  <= w_half;
                        r_bidx <= 2'd0;
                    end
                    ST_DATA: begin
                        r_bidx <= r_bidx + 2'd1;
                        case (r_bidx)
                            2'd0: r_word[7:0]   <= w_byte;
                            2'd1: r_word[15:8]  <= w_byte;
                            2'd2: r_word[23:16] <= w_byte;
                            default: begin
                                // Outputs only move when a write will follow,
                                // so they stay put between real writes.
                                if (!r_run) begin
                                    ram_addr <= r_wr_addr;
                                    ram_data <= {w_byte, r_word};
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            if (r_state == ST_WRITE) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
                r_cnt     <= r_cnt - 16'd1;
            end
        end
    end

endmodule : uart_loader
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_loader
//  Description : Directed self-checking bench for uart_loader with an RX
//                FIFO model and TX/RAM monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_empty;
    logic [7:0]        rx_q = 8'h00;
    logic              rx_rdreq;
    logic              tx_full = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_wrreq;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_we;
    logic              core_run;
    logic              busy;

    uart_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_empty (rx_empty),
        .rx_q     (rx_q),
        .rx_rdreq (rx_rdreq),
        .tx_full  (tx_full),
        .tx_data  (tx_data),
        .tx_wrreq (tx_wrreq),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .core_run (core_run),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // RX FIFO model
    logic [7:0] fifo_mem [0:255];
    logic [7:0] wp = 8'd0;
    logic [7:0] rp = 8'd0;
    assign rx_empty = (wp == rp);

    always @(posedge clk) begin
        if (rx_rdreq) begin
            rx_q <= fifo_mem[rp];
            rp   <= rp + 8'd1;
        end
    end

    // TX and RAM monitors
    int          tx_n = 0;
    logic [7:0]  tx_last = 8'h00;
    int          we_n = 0;
    logic [12:0] we_addr [0:15];
    logic [31:0] we_data [0:15];

    always @(posedge clk) begin
        if (tx_wrreq) begin
            tx_n    <= tx_n + 1;
            tx_last <= tx_data;
        end
        if (ram_we) begin
            if (we_n < 16) begin
                we_addr[we_n] <= ram_addr;
                we_data[we_n] <= ram_data;
            end
            we_n <= we_n + 1;
        end
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wp] = b;
        wp = wp + 8'd1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Wait for one response byte; a missing response counts as a failure.
    task automatic wait_tx(input string tag, input int budget, output int elapsed);
        int start;
        start   = tx_n;
        elapsed = 0;
        while (tx_n == start && elapsed < budget) begin
            @(negedge clk);
            elapsed++;
        end
        chk(tag, tx_n, start + 1);
    endtask

    int el;
    int we0;
    int tx0;

    initial begin
        // Reset state
        cycles(3);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_ram_we",   {31'd0, ram_we},   32'd0);
        chk("rst_tx_wrreq", {31'd0, tx_wrreq}, 32'd0);
        chk("rst_core_run", {31'd0, core_run}, 32'd0);
        chk("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
        rst = 1'b0;
        cycles(2);

        // Single-word write
        we0 = we_n;
        push(8'hA5); push(8'h00); push(8'h10); push(8'h00); push(8'h01);
        push(8'h78); push(8'h56); push(8'h34); push(8'h12);
        wait_tx("w1_resp", 200, el);
        chk("w1_ack",     {24'd0, tx_last}, 32'h06);
        chk("w1_nwrites", we_n - we0, 1);
        chk("w1_addr",    {19'd0, we_addr[we0]}, 32'h0010);
        chk("w1_data",    we_data[we0], 32'h12345678);
        chk("w1_idle",    {31'd0, busy}, 32'd0);
        cycles(5);
        chk("w1_hold_addr", {19'd0, ram_addr}, 32'h0010);
        chk("w1_hold_data", ram_data, 32'h12345678);

        // Two words with address wrap
        we0 = we_n;
        tx0 = tx_n;
        push(8'hA5); push(8'h1F); push(8'hFF); push(8'h00); push(8'h02);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        wait_tx("w2_resp", 200, el);
        chk("w2_ack",     {24'd0, tx_last}, 32'h06);
        chk("w2_nwrites", we_n - we0, 2);
        chk("w2_addr0",   {19'd0, we_addr[we0]}, 32'h1FFF);
        chk("w2_data0",   we_data[we0], 32'h44332211);
        chk("w2_addr1",   {19'd0, we_addr[we0+1]}, 32'h0000);
        chk("w2_data1",   we_data[we0+1], 32'h88776655);
        cycles(5);
        chk("w2_single_resp", tx_n - tx0, 1);

        // Unknown command, then zero-count write
        push(8'h3C);
        wait_tx("unk_resp", 50, el);
        chk("unk_nak", {24'd0, tx_last}, 32'h15);
        we0 = we_n;
        push(8'hA5); push(8'h00); push(8'h00); push(8'h00); push(8'h00);
        wait_tx("cnt0_resp", 100, el);
        chk("cnt0_ack",      {24'd0, tx_last}, 32'h06);
        chk("cnt0_nwrites",  we_n - we0, 0);

        // Inter-byte timeout, then a normal packet
        push(8'hA5); push(8'h00); push(8'h00);
        wait_tx("tmo_resp", 300, el);
        chk("tmo_nak",    {24'd0, tx_last}, 32'h15);
        chk("tmo_window", {31'd0, (el >= 100 && el <= 120)}, 32'd1);
        we0 = we_n;
        push(8'hA5); push(8'h00); push(8'h20); push(8'h00); push(8'h01);
        push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
        wait_tx("post_tmo_resp", 200, el);
        chk("post_tmo_ack",  {24'd0, tx_last}, 32'h06);
        chk("post_tmo_n",    we_n - we0, 1);
        chk("post_tmo_addr", {19'd0, we_addr[we0]}, 32'h0020);
        chk("post_tmo_data", we_data[we0], 32'hDEADBEEF);

        // TX back-pressure holds the FSM in RESP
        tx_full = 1'b1;
        tx0 = tx_n;
        push(8'h3C);
        cycles(20);
        chk("full_no_wr",  tx_n - tx0, 0);
        chk("full_wrreq",  {31'd0, tx_wrreq}, 32'd0);
        chk("full_busy",   {31'd0, busy}, 32'd1);
        tx_full = 1'b0;
        wait_tx("full_release", 20, el);
        chk("full_nak", {24'd0, tx_last}, 32'h15);
        cycles(5);
        chk("full_once", tx_n - tx0, 1);

        // Reset in the middle of DATA
        we0 = we_n;
        tx0 = tx_n;
        push(8'hA5); push(8'h00); push(8'h30); push(8'h00); push(8'h02);
        push(8'h01); push(8'h02);
        cycles(20);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
        chk("mid_rst_addr",  {19'd0, ram_addr}, 32'd0);
        chk("mid_rst_data",  ram_data, 32'd0);
        cycles(20);
        chk("mid_rst_no_tx", tx_n - tx0, 0);
        chk("mid_rst_no_we", we_n - we0, 0);

        // RUN, then WRITE while running is refused
        push(8'hFF);
        wait_tx("run_resp", 50, el);
        chk("run_ack", {24'd0, tx_last}, 32'h06);
        chk("run_set", {31'd0, core_run}, 32'd1);
        we0 = we_n;
        push(8'hA5); push(8'h00); push(8'h00); push(8'h00); push(8'h01);
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        wait_tx("runw_resp", 200, el);
        chk("runw_nak",    {24'd0, tx_last}, 32'h15);
        chk("runw_no_we",  we_n - we0, 0);
        chk("runw_sticky", {31'd0, core_run}, 32'd1);
        chk("runw_empty",  {31'd0, rx_empty}, 32'd1);
        push(8'hFF);
        wait_tx("run2_resp", 50, el);
        chk("run2_ack", {24'd0, tx_last}, 32'h06);

        // Only reset clears the run flag
        rst = 1'b1;
        cycles(2);
        chk("run_cleared", {31'd0, core_run}, 32'd0);
        rst = 1'b0;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_loader
`default_nettype wire
